// File: rtl/fir_sample_source.sv
// fir_sample_source: valid/ready sample transmitter for the FIR filter input.
// After a start it emits a programmed number of ramp or 8-bit LFSR samples.
// An optional run of idle cycles can follow each non-final sample.
// Optional feature macro: FIR_SRC_CKSUM_EN adds the io_sum running checksum port.
module fir_sample_source #(
  parameter int DATA_W  = 8,
  parameter int COUNT_W = 8,
  parameter int GAP_W   = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               io_start,
  input  logic               io_mode,
  input  logic [DATA_W-1:0]  io_seed,
  input  logic [COUNT_W-1:0] io_num_samples,
  input  logic [GAP_W-1:0]   io_gap,
  input  logic               io_ready,
  output logic               io_valid_out,
  output logic [DATA_W-1:0]  io_x,
  output logic               io_busy,
  output logic               io_done
`ifdef FIR_SRC_CKSUM_EN
  ,
  output logic [DATA_W+COUNT_W-1:0] io_sum
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_mode;
  logic [GAP_W-1:0]    r_gap_len;
  logic [GAP_W-1:0]    r_gap_cnt;
  logic [COUNT_W-1:0]  r_remain;
  logic [DATA_W-1:0]   r_x;
  logic                r_valid;
  logic                r_busy;
  logic                r_done;
  logic                w_accept;
  logic                w_xfer;
  logic                w_last;

  // First sample of a run: the seed for ramp mode, the fixed-up 8-bit seed for LFSR mode.
  function automatic logic [DATA_W-1:0] f_first_x(input logic mode, input logic [DATA_W-1:0] seed);
    logic [DATA_W-1:0] v;
    v = '0;
    if (mode) begin
      if (seed[7:0] == 8'h00) begin
        v[7:0] = 8'h01;          // all-zero is the LFSR lock-up state
      end else begin
        v[7:0] = seed[7:0];
      end
    end else begin
      v = seed;
    end
    return v;
  endfunction

  // Successor sample: ramp increments with wrap; LFSR x^8+x^6+x^5+x^4+1 on the low byte.
  function automatic logic [DATA_W-1:0] f_next_x(input logic mode, input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] v;
    v = '0;
    if (mode) begin
      v[7:0] = {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    end else begin
      v = x + DATA_W'(1);
    end
    return v;
  endfunction

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and transfer strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_xfer      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (io_start) begin
          w_accept = 1'b1;
          if (io_num_samples != '0) begin
            w_state_nxt = S_SEND;
          end else begin
            w_state_nxt = S_DONE;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SEND: begin
        // valid is always high in SEND, so a transfer is just ready
        w_xfer = io_ready;
        w_last = io_ready && (r_remain == COUNT_W'(1));
        if (io_ready) begin
          if (r_remain == COUNT_W'(1)) begin
            w_state_nxt = S_DONE;
          end else if (r_gap_len != '0) begin
            w_state_nxt = S_GAP;
          end else begin
            w_state_nxt = S_SEND;
          end
        end else begin
          w_state_nxt = S_SEND;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == GAP_W'(1)) begin
          w_state_nxt = S_SEND;
        end else begin
          w_state_nxt = S_GAP;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Run parameters, remaining count, gap counter and current sample.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_mode    <= 1'b0;
      r_gap_len <= '0;
      r_gap_cnt <= '0;
      r_remain  <= '0;
      r_x       <= '0;
    end else begin
      if (w_accept) begin
        r_mode    <= io_mode;
        r_gap_len <= io_gap;
        r_remain  <= io_num_samples;
        if (io_num_samples != '0) begin
          r_x <= f_first_x(io_mode, io_seed);
        end
      end else if (w_xfer) begin
        r_remain <= r_remain - COUNT_W'(1);
        r_x      <= f_next_x(r_mode, r_x);
      end
      if (w_xfer && !w_last) begin
        r_gap_cnt <= r_gap_len;
      end else if (r_state == S_GAP) begin
        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
      end
    end
  end

  // Status outputs registered from the next state so they line up with r_state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_valid <= (w_state_nxt == S_SEND);
      r_busy  <= (w_state_nxt == S_SEND) || (w_state_nxt == S_GAP);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  assign io_valid_out = r_valid;
  assign io_busy      = r_busy;
  assign io_done      = r_done;
  assign io_x         = r_x;

`ifdef FIR_SRC_CKSUM_EN
  logic [DATA_W+COUNT_W-1:0] r_sum;

  // Running sum of transferred samples; wide enough for a full-length run.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sum <= '0;
    end else if (w_accept) begin
      r_sum <= '0;
    end else if (w_xfer) begin
      r_sum <= r_sum + {{COUNT_W{1'b0}}, r_x};
    end
  end

  assign io_sum = r_sum;
`endif

endmodule
